goto_rep_monitor: RTL and testbench

- Synthesizable hardware checker for the property "rose(sig) |-> sig[->N_HITS] ##1 sig".
- Sits downstream of the control-signal stimulus (sig and ce patterns driven by the bench or by the DUT's control logic) and consumes them.
- Emits one-cycle pass/fail verdict pulses, so on-chip logic or an FPGA ILA can check the same temporal rule that the bench asserts in simulation.

---
 rtl/goto_rep_pkg.sv | 5 +
 rtl/sat_counter.sv | 18 +
 rtl/goto_rep_monitor.sv | 89 ++++++++
 tb/tb_goto_rep_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/goto_rep_pkg.sv
// goto_rep_pkg: shared types and defaults for the goto-repetition monitor
package goto_rep_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, CHECK} mon_state_t;
    localparam int MON_CNT_W_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clr wins over inc)
// Ports: clk, rst (async, active-high), clr, inc, q (current count)
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = clr ? '0 : (inc && q_q != '1) ? q_q + 1'b1 : q_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= '0;
        else q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/goto_rep_monitor.sv
// goto_rep_monitor: on-chip checker for "rose(sig) |-> sig[->N_HITS] ##1 sig" with pass/fail pulses
// Ports: clk, rst (async, active-high), ce (sample enable), sig (monitored),
//        busy (attempt in progress), hit_cnt (occurrences so far), pass/fail (one-cycle verdicts),
//        fail_timeout (qualifies fail when TIMEOUT expired).
// Optional GOTO_REP_MON_STATS_EN adds pass_total/fail_total/drop_total saturating statistics.
module goto_rep_monitor import goto_rep_pkg::*; #(
    parameter int N_HITS  = 2,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = MON_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             sig,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             pass,
    output logic             fail,
    output logic             fail_timeout
`ifdef GOTO_REP_MON_STATS_EN
    ,
    output logic [CNT_W-1:0] pass_total,
    output logic [CNT_W-1:0] fail_total,
    output logic [CNT_W-1:0] drop_total
`endif
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W:0] HIT_LAST = (CNT_W + 1)'(N_HITS);
    mon_state_t state_q, state_d;
    logic sig_q, rise, hit_done, to_hit;
    logic hit_inc, hit_clr, tmr_inc, tmr_clr, drop;
    logic pass_q, pass_d, fail_q, fail_d, to_q, to_d;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W:0] hit_next;
    logic [TW-1:0] timer_q;
    assign rise     = sig & ~sig_q;
    assign hit_next = {1'b0, hit_cnt_q} + 1'b1;
    assign hit_done = hit_next == HIT_LAST;
    // timer_q lags the COUNT cycle count by one, so TO_LAST marks the TIMEOUT-th COUNT cycle;
    // reaching N_HITS on that same cycle takes precedence over the timeout
    assign to_hit   = (TIMEOUT > 0) && timer_q == TO_LAST && !(sig && hit_done);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            sig_q   <= sig;
        end
    always_comb
        state_d = state_q == IDLE  ? (rise ? (N_HITS == 1 ? CHECK : COUNT) : IDLE) :
                  state_q == COUNT ? (sig && hit_done ? CHECK : to_hit ? IDLE : COUNT) : IDLE;
    always_comb begin
        busy    = state_q != IDLE;
        hit_inc = ce && ((state_q == IDLE && rise) || (state_q == COUNT && sig));
        hit_clr = ce && (state_q == CHECK || (state_q == COUNT && to_hit));
        tmr_inc = ce && state_q == COUNT;
        tmr_clr = ce && state_d != COUNT;
        pass_d  = ce && state_q == CHECK && sig;
        to_d    = ce && state_q == COUNT && to_hit;
        fail_d  = (ce && state_q == CHECK && !sig) || to_d;
        drop    = ce && busy && rise;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            to_q   <= to_d;
        end
    sat_counter #(.W(CNT_W)) u_hit (.clk(clk), .rst(rst), .clr(hit_clr), .inc(hit_inc), .q(hit_cnt_q));
    sat_counter #(.W(TW)) u_tmr (.clk(clk), .rst(rst), .clr(tmr_clr), .inc(tmr_inc), .q(timer_q));
`ifdef GOTO_REP_MON_STATS_EN
    sat_counter #(.W(CNT_W)) u_pass_tot (.clk(clk), .rst(rst), .clr(1'b0), .inc(pass_d), .q(pass_total));
    sat_counter #(.W(CNT_W)) u_fail_tot (.clk(clk), .rst(rst), .clr(1'b0), .inc(fail_d), .q(fail_total));
    sat_counter #(.W(CNT_W)) u_drop_tot (.clk(clk), .rst(rst), .clr(1'b0), .inc(drop), .q(drop_total));
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
    assign hit_cnt      = hit_cnt_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign fail_timeout = to_q;
endmodule

// File: tb/tb_goto_rep_monitor.sv
// tb_goto_rep_monitor: directed + randomized check of two monitor configurations against a counting model
module tb_goto_rep_monitor;
    logic clk = 1'b0, rst, ce, sig;
    logic busy_w[2], pass_w[2], fail_w[2], to_w[2];
    logic [7:0] hit_w[2];
`ifdef GOTO_REP_MON_STATS_EN
    logic [7:0] pt_w[2], ft_w[2], dt_w[2];
`endif
    always #5 clk = ~clk;

    goto_rep_monitor #(.N_HITS(2), .TIMEOUT(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .sig(sig), .busy(busy_w[0]), .hit_cnt(hit_w[0]),
        .pass(pass_w[0]), .fail(fail_w[0]), .fail_timeout(to_w[0])
`ifdef GOTO_REP_MON_STATS_EN
        , .pass_total(pt_w[0]), .fail_total(ft_w[0]), .drop_total(dt_w[0])
`endif
    );
    goto_rep_monitor #(.N_HITS(3), .TIMEOUT(5), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .sig(sig), .busy(busy_w[1]), .hit_cnt(hit_w[1]),
        .pass(pass_w[1]), .fail(fail_w[1]), .fail_timeout(to_w[1])
`ifdef GOTO_REP_MON_STATS_EN
        , .pass_total(pt_w[1]), .fail_total(ft_w[1]), .drop_total(dt_w[1])
`endif
    );

    int tests = 0, fails = 0;
    bit act[2], ep[2], ef[2], et[2], prev;
    int hits[2], age[2], pt[2], ft[2], dt[2];

    function automatic int need(input int i);
        return i == 0 ? 2 : 3;
    endfunction
    function automatic int limit(input int i);
        return i == 0 ? 0 : 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; hits[i] = 0; age[i] = 0;
            ep[i] = 0; ef[i] = 0; et[i] = 0;
            pt[i] = 0; ft[i] = 0; dt[i] = 0;
        end
    endtask

    task automatic model_edge(input bit c, input bit s);
        bit r;
        r = s & ~prev;
        for (int i = 0; i < 2; i++) begin
            ep[i] = 0; ef[i] = 0; et[i] = 0;
            if (c) begin
                if (!act[i]) begin
                    if (r) begin act[i] = 1; hits[i] = 1; age[i] = 0; end
                end else begin
                    if (r && dt[i] < 255) dt[i]++;
                    if (hits[i] >= need(i)) begin
                        ep[i] = s; ef[i] = !s; act[i] = 0; hits[i] = 0;
                    end else begin
                        age[i]++;
                        if (s) hits[i]++;
                        if (hits[i] < need(i) && limit(i) > 0 && age[i] >= limit(i)) begin
                            ef[i] = 1; et[i] = 1; act[i] = 0; hits[i] = 0;
                        end
                    end
                end
                if (ep[i] && pt[i] < 255) pt[i]++;
                if (ef[i] && ft[i] < 255) ft[i]++;
            end
        end
        if (c) prev = s;
    endtask

    task automatic check_all();
        string p;
        for (int i = 0; i < 2; i++) begin
            p = i == 0 ? "a" : "b";
            chk({p, "_busy"}, busy_w[i], act[i]);
            chk({p, "_hit_cnt"}, hit_w[i], hits[i]);
            chk({p, "_pass"}, pass_w[i], ep[i]);
            chk({p, "_fail"}, fail_w[i], ef[i]);
            chk({p, "_fail_timeout"}, to_w[i], et[i]);
`ifdef GOTO_REP_MON_STATS_EN
            chk({p, "_pass_total"}, pt_w[i], pt[i]);
            chk({p, "_fail_total"}, ft_w[i], ft[i]);
            chk({p, "_drop_total"}, dt_w[i], dt[i]);
`endif
        end
    endtask

    task automatic step(input bit c, input bit s);
        ce = c; sig = s;
        @(posedge clk);
        model_edge(c, s);
        #1 check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_clear();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) step(1, 1);
        for (int k = 0; k < 8; k++) step(1, 0);
    endtask

    initial begin
        ce = 1'b0; sig = 1'b0;
        apply_reset();
        chk("reset_busy", busy_w[0], 0);
        chk("reset_pass", pass_w[0], 0);
        // N_HITS=2 pass: 0,1,0,1,1
        step(1, 0); step(1, 1); step(1, 0); step(1, 1);
        chk("d1_in_check", busy_w[0], 1);
        step(1, 1);
        chk("d1_pass", pass_w[0], 1);
        chk("d1_hit_cleared", hit_w[0], 0);
        step(1, 0);
        chk("d1_pass_one_cycle", pass_w[0], 0);
        flush();
        // N_HITS=2 fail: 0,1,0,1,0
        step(1, 0); step(1, 1); step(1, 0); step(1, 1); step(1, 0);
        chk("d2_fail", fail_w[0], 1);
        chk("d2_not_timeout", to_w[0], 0);
        flush();
        // SVA waveform sampled at 5/15/25/...: 0,0,0,0,1,1,1
        step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(1, 1); step(1, 1); step(1, 1);
        chk("sva_pass", pass_w[0], 1);
        step(1, 0);
        flush();
        // timeout on dut_b: single rise then sig low
        step(1, 1);
        for (int k = 0; k < 4; k++) begin
            step(1, 0);
            chk("to_early_fail", fail_w[1], 0);
        end
        step(1, 0);
        chk("to_fail", fail_w[1], 1);
        chk("to_flag", to_w[1], 1);
        chk("to_idle", busy_w[1], 0);
        flush();
        // ce held low mid-COUNT with sig high
        step(1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1);
            chk("ce_hold_hit", hit_w[0], 1);
            chk("ce_no_pass", pass_w[0], 0);
        end
        step(1, 1);
        chk("ce_resume_hit", hit_w[0], 2);
        step(1, 1);
        chk("ce_resume_pass", pass_w[0], 1);
        flush();
        // async reset mid-COUNT, then a rise while busy
        step(1, 1);
        chk("ar_hit1", hit_w[0], 1);
        #2 rst = 1'b1;
        #1 chk("ar_busy_cleared", busy_w[0], 0);
        chk("ar_hit_cleared", hit_w[0], 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0); step(1, 1); step(1, 0);
        chk("ar_no_verdict", fail_w[0], 0);
        step(1, 1);
`ifdef GOTO_REP_MON_STATS_EN
        chk("drop_total_1", dt_w[0], 1);
`endif
        flush();
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) apply_reset();
            step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
